// File: rtl/eater_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | eater_pkg                                                             |
// | Shared constants for the 8-bit computer and its serial program loader.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package eater_pkg;

    typedef logic [2:0] ld_state_t;

    localparam ld_state_t LD_IDLE      = 3'd0;
    localparam ld_state_t LD_WAIT_BYTE = 3'd1;
    localparam ld_state_t LD_WR_ADDR   = 3'd2;
    localparam ld_state_t LD_WR_DATA   = 3'd3;
    localparam ld_state_t LD_CHECK     = 3'd4;
    localparam ld_state_t LD_DONE      = 3'd5;
    localparam ld_state_t LD_ERROR     = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FRAME   = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    // Control-word bit positions shared by microcode ROM and bus mux.
    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

endpackage : eater_pkg
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx_byte                                                          |
// | 8N1 UART receiver: synchroniser, bit timer, LSB-first shift register. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int c_cw = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_full = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_half = c_cw'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]      r_sync;
    logic [1:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_valid;
    logic            r_ferr;
    logic            w_rx;

    assign w_rx       = r_sync[1];
    assign data       = r_shift;
    assign byte_valid = r_valid;
    assign frame_err  = r_ferr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start-bit re-check filters short low glitches.
                    if (r_cnt == c_half) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_full) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_full) begin
                        r_cnt   <= '0;
                        r_valid <= w_rx;
                        r_ferr  <= ~w_rx;
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prog_loader                                                           |
// | Loads a program over UART into RAM via MI/RI, then checks checksum.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module prog_loader
    import eater_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    input  logic       start,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       mi,
    output logic       ri,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam logic [4:0] c_num_bytes = 5'(NUM_BYTES);

    logic [7:0] w_data;
    logic       w_valid;
    logic       w_ferr;
    logic       w_fault;
    logic [1:0] w_fault_code;

    ld_state_t  r_state;
    logic [4:0] r_cnt;
    logic [7:0] r_csum;
    logic [7:0] r_byte;
    logic [7:0] r_bus_out;
    logic       r_bus_oe;
    logic       r_mi;
    logic       r_ri;
    logic       r_hold;
    logic       r_busy;
    logic       r_done;
    logic [1:0] r_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .clr       (clr),
        .rx        (rx),
        .data      (w_data),
        .byte_valid(w_valid),
        .frame_err (w_ferr)
    );

    // A byte landing mid-write means the previous one was never stored.
    always_comb begin
        w_fault      = 1'b0;
        w_fault_code = ERR_NONE;
        case (r_state)
            LD_WAIT_BYTE, LD_CHECK: begin
                if (w_ferr) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_FRAME;
                end
            end
            LD_WR_ADDR, LD_WR_DATA: begin
                if (w_ferr) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_FRAME;
                end else if (w_valid) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_OVERRUN;
                end
            end
            default: begin
                w_fault      = 1'b0;
                w_fault_code = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= LD_IDLE;
            r_cnt     <= '0;
            r_csum    <= '0;
            r_byte    <= '0;
            r_bus_out <= '0;
            r_bus_oe  <= 1'b0;
            r_mi      <= 1'b0;
            r_ri      <= 1'b0;
            r_hold    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= ERR_NONE;
        end else begin
            r_bus_oe <= 1'b0;
            r_mi     <= 1'b0;
            r_ri     <= 1'b0;
            if (w_fault) begin
                r_state <= LD_ERROR;
                r_err   <= w_fault_code;
                r_hold  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    LD_IDLE, LD_DONE, LD_ERROR: begin
                        if (start) begin
                            r_state <= LD_WAIT_BYTE;
                            r_hold  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_err   <= ERR_NONE;
                            r_cnt   <= '0;
                            r_csum  <= '0;
                        end
                    end
                    LD_WAIT_BYTE: begin
                        if (w_valid) begin
                            r_byte <= w_data;
                            if (r_cnt == c_num_bytes) begin
                                r_state <= LD_CHECK;
                            end else begin
                                r_csum    <= r_csum + w_data;
                                r_state   <= LD_WR_ADDR;
                                r_mi      <= 1'b1;
                                r_bus_oe  <= 1'b1;
                                r_bus_out <= {4'b0, r_cnt[3:0]};
                            end
                        end
                    end
                    LD_WR_ADDR: begin
                        r_state   <= LD_WR_DATA;
                        r_ri      <= 1'b1;
                        r_bus_oe  <= 1'b1;
                        r_bus_out <= r_byte;
                    end
                    LD_WR_DATA: begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= LD_WAIT_BYTE;
                    end
                    LD_CHECK: begin
                        r_hold <= 1'b0;
                        r_busy <= 1'b0;
                        if (r_byte == r_csum) begin
                            r_state <= LD_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= LD_ERROR;
                            r_err   <= ERR_CSUM;
                        end
                    end
                    default: r_state <= LD_IDLE;
                endcase
            end
        end
    end

    assign bus_out  = r_bus_out;
    assign bus_oe   = r_bus_oe;
    assign mi       = r_mi;
    assign ri       = r_ri;
    assign cpu_hold = r_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_prog_loader                                                        |
// | Directed + randomized checks of the loader against a RAM/sum model.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_prog_loader;

    localparam int CPB = 16;
    localparam int NB  = 16;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       rx = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       mi;
    logic       ri;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [1:0] err;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx [NB];
    logic [7:0] ram [NB];
    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         protocol_bad = 0;
    bit         mi_prev = 1'b0;
    logic [7:0] addr_prev = '0;
    bit         rst_hit = 1'b0;

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NB)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .rx      (rx),
        .start   (start),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .mi      (mi),
        .ri      (ri),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Bus-side model: MAR loads on MI, RAM writes on the following RI.
    always @(negedge clk) begin
        if (!clr) begin
            mi_prev = 1'b0;
        end else begin
            if (mi_prev) begin
                if (!(ri && !mi && bus_oe)) begin
                    protocol_bad++;
                end else begin
                    wr_addr_q.push_back(addr_prev);
                    wr_data_q.push_back(bus_out);
                    ram[addr_prev[3:0]] = bus_out;
                end
            end else if (ri) begin
                protocol_bad++;
            end
            if (bus_oe && !mi && !ri) protocol_bad++;
            if (mi) begin
                if (!bus_oe || ri || bus_out[7:4] != 4'h0) protocol_bad++;
                addr_prev = bus_out;
                mi_prev   = 1'b1;
            end else begin
                mi_prev = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_sum();
        int s = 0;
        for (int i = 0; i < NB; i++) s += int'(tx[i]);
        return 8'(s % 256);
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit rst_on_ri);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (rst_on_ri && ri && clr && !rst_hit) begin
                clr = 1'b0;
                rst_hit = 1'b1;
                #1;
                chk("reset_mid_write_outputs",
                    {16'h0, bus_out, bus_oe, mi, ri, cpu_hold, busy, done, err}, 32'h0);
            end
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_model();
        wr_addr_q.delete();
        wr_data_q.delete();
        protocol_bad = 0;
        for (int i = 0; i < NB; i++) ram[i] = 8'h00;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // frame_idx: byte index sent with a bad stop bit (-1 none).
    // restart_idx: pulse start again after this byte (-1 none).
    task automatic run_load(input string tag, input logic [7:0] csum,
                            input int frame_idx, input int restart_idx);
        int         n;
        int         bad;
        bit         ok;
        logic [1:0] exp_err;
        logic [7:0] b;
        clear_model();
        pulse_start();
        chk({tag, "_busy_hold"}, {busy, cpu_hold, done, err}, 5'b11000);
        for (int i = 0; i <= NB; i++) begin
            b = (i < NB) ? tx[i] : csum;
            send_byte(b, (i != frame_idx), 1'b0);
            if (i == restart_idx) pulse_start();
            if (i == frame_idx) break;
        end
        wait_idle(CPB, ok);
        chk({tag, "_finish_timeout"}, 32'(ok), 32'd1);

        n = (frame_idx >= 0) ? frame_idx : NB;
        if (frame_idx >= 0)         exp_err = 2'd1;
        else if (csum == model_sum()) exp_err = 2'd0;
        else                        exp_err = 2'd3;

        chk({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'(n));
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < n; i++) begin
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== tx[i]) bad++;
        end
        chk({tag, "_write_contents"}, 32'(bad), 32'd0);
        chk({tag, "_strobe_protocol"}, 32'(protocol_bad), 32'd0);
        bad = 0;
        for (int i = 0; i < NB; i++) begin
            if (ram[i] !== ((i < n) ? tx[i] : 8'h00)) bad++;
        end
        chk({tag, "_ram_dump"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(exp_err == 2'd0));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_hold_busy"}, {cpu_hold, busy}, 2'b00);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < NB; i++) ram[i] = 8'h00;

        #1;
        chk("reset_outputs", {16'h0, bus_out, bus_oe, mi, ri, cpu_hold, busy, done, err}, 32'h0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);

        // Traffic while idle must be ignored.
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        chk("idle_traffic_ignored", {busy, done, err, mi, ri}, 6'b0);

        tx = '{8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0E, 8'h1C};
        // These bytes sum to 0x47 mod 256; 0x2D and 0x2C are both mismatches.
        run_load("normal", model_sum(), -1, -1);
        run_load("csum_2d", 8'h2D, -1, -1);
        run_load("csum_2c", 8'h2C, -1, -1);
        run_load("frame_err", model_sum(), 4, -1);
        run_load("start_while_busy", model_sum(), -1, 2);

        // Glitch on rx while waiting for a byte.
        clear_model();
        pulse_start();
        @(negedge clk) rx = 1'b0;
        repeat (CPB / 4 - 1) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_no_write", 32'(wr_addr_q.size()), 32'd0);
        chk("glitch_state", {busy, cpu_hold, err}, 4'b1100);
        send_byte(8'hA5, 1'b1, 1'b0);
        chk("glitch_then_write", {wr_addr_q.size() == 1 ? 8'h01 : 8'hFF,
                                  wr_addr_q.size() > 0 ? wr_addr_q[0] : 8'hFF,
                                  wr_data_q.size() > 0 ? wr_data_q[0] : 8'h00},
            24'h01_00_A5);
        clr = 1'b0;
        @(negedge clk) clr = 1'b1;
        @(negedge clk);

        // Reset during the write of byte 7.
        for (int i = 0; i < NB; i++) tx[i] = 8'($urandom);
        clear_model();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(tx[i], 1'b1, 1'b0);
        rst_hit = 1'b0;
        send_byte(tx[6], 1'b1, 1'b1);
        chk("reset_hit_during_write", 32'(rst_hit), 32'd1);
        chk("reset_held_idle", {busy, cpu_hold, done, err}, 5'b0);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        run_load("after_reset", model_sum(), -1, -1);

        // Randomized loads, some with a corrupted checksum.
        for (int r = 0; r < 3; r++) begin
            logic [7:0] cs;
            for (int i = 0; i < NB; i++) tx[i] = 8'($urandom);
            cs = model_sum();
            if ($urandom_range(0, 1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
            run_load($sformatf("rand%0d", r), cs, -1, -1);
        end

        wait_idle(4, ok);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
